// File: rtl/dmem_resp_pkg.sv
// rtl/dmem_resp_pkg.sv - shared state encoding and width helper for the data-memory responder
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between a load/store requester and the responder
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_word_array.sv
// rtl/dmem_word_array.sv - DEPTH x 32 single-port synchronous RAM with byte write enables
module dmem_word_array
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [0:DEPTH-1];
    logic [31:0] r_q;

    always_ff @(posedge clock) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end else begin
                r_q <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder: one outstanding request, fixed wait states, fault flagging
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic clock,
    input  logic reset,
    dmem_responder_if.slave bus
);

    localparam int AW = clog2(DEPTH);

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_range
            $error("dmem_responder: WAIT_STATES must be within 0..15");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_pow2
            $error("dmem_responder: DEPTH must be a power of two >= 2");
        end
    endgenerate

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_req_ready;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_rsp_err;
    logic        r_rsp_load;

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_acc_we;
    logic [31:0] w_acc_addr;
    logic [3:0]  w_acc_be;
    logic [31:0] w_acc_wdata;
    logic        w_fault;
    logic [31:0] w_ram_q;

    assign w_accept = bus.req_valid & r_req_ready;

    // With zero wait states the access happens on the acceptance edge, before capture regs load.
    assign w_acc_we    = (r_state == IDLE) ? bus.req_we    : r_we;
    assign w_acc_addr  = (r_state == IDLE) ? bus.req_addr  : r_addr;
    assign w_acc_be    = (r_state == IDLE) ? bus.req_be    : r_be;
    assign w_acc_wdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;

    assign w_fault = (w_acc_addr[1:0] != 2'b00) ||
                     ({2'b00, w_acc_addr[31:2]} >= 32'(DEPTH));

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nxt  = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt  = RESP;
                    w_enter_resp = 1'b1;
                    w_cnt_nxt    = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_be        <= 4'd0;
            r_wdata     <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_rsp_load  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            // Registered so a completing response cannot overlap a new acceptance.
            r_req_ready <= (w_state_nxt == IDLE);
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_be    <= bus.req_be;
                r_wdata <= bus.req_wdata;
            end
            if (w_enter_resp) begin
                r_rsp_err  <= w_fault;
                r_rsp_load <= ~w_acc_we;
            end
        end
    end

    dmem_word_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clock   (clock),
        .i_en    (w_enter_resp & ~w_fault),
        .i_we    (w_acc_we),
        .i_be    (w_acc_be),
        .i_addr  (w_acc_addr[AW+1:2]),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_ram_q)
    );

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_err   = (r_state == RESP) & r_rsp_err;
    assign bus.rsp_rdata = ((r_state == RESP) && r_rsp_load && !r_rsp_err) ? w_ram_q : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench with a cycle-level reference model for dmem_responder
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_ready = 1'b1;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder_if if0 ();
    dmem_responder_if if1 ();

    assign if0.req_valid = req_valid & ~sel;
    assign if1.req_valid = req_valid & sel;
    assign if0.req_we = req_we;       assign if1.req_we = req_we;
    assign if0.req_addr = req_addr;   assign if1.req_addr = req_addr;
    assign if0.req_be = req_be;       assign if1.req_be = req_be;
    assign if0.req_wdata = req_wdata; assign if1.req_wdata = req_wdata;
    assign if0.rsp_ready = rsp_ready; assign if1.rsp_ready = rsp_ready;

    assign req_ready = sel ? if1.req_ready : if0.req_ready;
    assign rsp_valid = sel ? if1.rsp_valid : if0.rsp_valid;
    assign rsp_rdata = sel ? if1.rsp_rdata : if0.rsp_rdata;
    assign rsp_err   = sel ? if1.rsp_err   : if0.rsp_err;

    dmem_responder #(.DEPTH(256), .WAIT_STATES(2)) dut0 (.clock(clk), .reset(rst_n), .bus(if0));
    dmem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut1 (.clock(clk), .reset(rst_n), .bus(if1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: per-DUT word memory, one outstanding transaction, response due WS+1 cycles after accept.
    logic [31:0] mdl_mem [2][256];
    int          cyc = 0;
    bit          rst_prev = 0;
    bit          outst = 0;
    bit          resp_on = 0;
    int          acc_cyc = 0;
    int          ws;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, e_rdata;
    logic [3:0]  m_be;
    logic        e_err, e_ready;
    int          m_sel;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("reset req_ready", {31'd0, req_ready}, 32'd0);
            chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("reset rsp_rdata", rsp_rdata, 32'd0);
            chk("reset rsp_err", {31'd0, rsp_err}, 32'd0);
            outst = 0;
            resp_on = 0;
            rst_prev = 0;
        end else begin
            ws = sel ? 0 : 2;
            m_sel = sel ? 1 : 0;
            e_ready = rst_prev && !outst;
            chk("req_ready", {31'd0, req_ready}, {31'd0, e_ready});
            if (outst && !resp_on && cyc == acc_cyc + ws + 1) begin
                resp_on = 1;
                e_err = (m_addr[1:0] != 2'b00) || (m_addr[31:2] >= 30'd256);
                e_rdata = 32'd0;
                if (!e_err && m_we) begin
                    for (int b = 0; b < 4; b++)
                        if (m_be[b]) mdl_mem[m_sel][m_addr[9:2]][8*b +: 8] = m_wdata[8*b +: 8];
                end else if (!e_err) begin
                    e_rdata = mdl_mem[m_sel][m_addr[9:2]];
                end
            end
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, resp_on});
            if (resp_on) begin
                chk("rsp_rdata", rsp_rdata, e_rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
                if (rsp_ready) begin
                    outst = 0;
                    resp_on = 0;
                end
            end
            if (req_valid && e_ready) begin
                outst = 1;
                acc_cyc = cyc;
                m_we = req_we;
                m_addr = req_addr;
                m_be = req_be;
                m_wdata = req_wdata;
            end
            rst_prev = 1;
        end
    end

    logic [31:0] got_rdata;
    logic        got_err;
    int          got_lat;

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
        int t;
        bit ok;
        req_we = we; req_addr = addr; req_be = be; req_wdata = wdata; req_valid = 1'b1;
        ok = 0;
        for (t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
        end
        if (!ok) begin
            chk("accept timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1 req_valid = 1'b0;
        got_lat = 0;
        ok = 0;
        for (t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            got_lat++;
            if (rsp_valid) ok = 1;
        end
        if (!ok) begin
            chk("response timeout", 32'd0, 32'd1);
            return;
        end
        got_rdata = rsp_rdata;
        got_err = rsp_err;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int acc[3];
        int tcnt;
        int i;
        logic [31:0] addrs[3];

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: store then load, latency 3 with two wait states
        do_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        chk("t1 store latency", got_lat, 32'd3);
        chk("t1 store err", {31'd0, got_err}, 32'd0);
        do_req(1'b0, 32'h10, 4'h0, 32'h0);
        chk("t1 load latency", got_lat, 32'd3);
        chk("t1 load rdata", got_rdata, 32'hDEADBEEF);

        // 2: partial byte write and empty-enable no-op store
        do_req(1'b1, 32'h10, 4'b0010, 32'h0000AA00);
        do_req(1'b0, 32'h10, 4'h0, 32'h0);
        chk("t2 partial rdata", got_rdata, 32'hDEADAAEF);
        do_req(1'b1, 32'h10, 4'h0, 32'hFFFFFFFF);
        chk("t2 be0 err", {31'd0, got_err}, 32'd0);
        do_req(1'b0, 32'h10, 4'h0, 32'h0);
        chk("t2 be0 rdata", got_rdata, 32'hDEADAAEF);

        // 3: top word, misaligned and out-of-range accesses
        do_req(1'b1, 32'h3FC, 4'hF, 32'h12345678);
        chk("t3 top store err", {31'd0, got_err}, 32'd0);
        do_req(1'b0, 32'h3FC, 4'h0, 32'h0);
        chk("t3 top rdata", got_rdata, 32'h12345678);
        do_req(1'b0, 32'h12, 4'h0, 32'h0);
        chk("t3 misaligned err", {31'd0, got_err}, 32'd1);
        chk("t3 misaligned rdata", got_rdata, 32'd0);
        do_req(1'b0, 32'h400, 4'h0, 32'h0);
        chk("t3 range err", {31'd0, got_err}, 32'd1);
        do_req(1'b1, 32'h400, 4'hF, 32'h55555555);
        chk("t3 range store err", {31'd0, got_err}, 32'd1);
        do_req(1'b0, 32'h0, 4'h0, 32'h0);
        do_req(1'b0, 32'h3FC, 4'h0, 32'h0);
        chk("t3 top unchanged", got_rdata, 32'h12345678);

        // 4: response back-pressure with a second request held pending
        rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_valid = 1'b1;
        tcnt = 0;
        do begin @(negedge clk); tcnt++; end while (!req_ready && tcnt < 20);
        @(posedge clk); #1 req_addr = 32'h3FC;
        tcnt = 0;
        do begin @(negedge clk); tcnt++; end while (!rsp_valid && tcnt < 20);
        chk("t4 rsp arrives", {31'd0, rsp_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("t4 held rdata", rsp_rdata, 32'hDEADAAEF);
            chk("t4 held req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4 handshake cycle ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("t4 next request accepted", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        tcnt = 0;
        do begin @(negedge clk); tcnt++; end while (!rsp_valid && tcnt < 20);
        chk("t4 second rdata", rsp_rdata, 32'h12345678);
        @(posedge clk); #1;

        // 5: reset during the wait of a store leaves memory untouched
        do_req(1'b1, 32'h20, 4'hF, 32'hA5A5A5A5);
        req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'h0BADF00D; req_valid = 1'b1;
        tcnt = 0;
        do begin @(negedge clk); tcnt++; end while (!req_ready && tcnt < 20);
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("t5 async rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t5 async req_ready", {31'd0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_req(1'b0, 32'h20, 4'h0, 32'h0);
        chk("t5 prior contents", got_rdata, 32'hA5A5A5A5);

        // 6: zero wait states, back-to-back loads
        repeat (2) @(posedge clk);
        #1 sel = 1'b1;
        do_req(1'b1, 32'h0, 4'hF, 32'h11112222);
        chk("t6 store latency", got_lat, 32'd1);
        do_req(1'b1, 32'h4, 4'hF, 32'h33334444);
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h0;
        req_we = 1'b0; req_be = 4'h0; req_addr = addrs[0]; req_valid = 1'b1;
        i = 0; tcnt = 0;
        while (i < 3 && tcnt < 30) begin
            @(negedge clk);
            tcnt++;
            if (req_ready) begin
                acc[i] = tcnt;
                i++;
                @(posedge clk); #1;
                if (i < 3) req_addr = addrs[i];
                else req_valid = 1'b0;
            end
        end
        chk("t6 accepts", i, 32'd3);
        chk("t6 spacing 1", acc[1] - acc[0], 32'd2);
        chk("t6 spacing 2", acc[2] - acc[1], 32'd2);
        repeat (3) @(posedge clk);
        #1 sel = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
